uart_fabric_rx: RTL and testbench
=================================

Name: uart_fabric_rx

Overview:
- Fabric-side UART receiver. Deserialises the serial stream driven by the MSS UART TX pin into bytes for fabric logic.
- Presents each byte on a valid/ready holding register and flags framing and overrun errors.
- Sits beside the MSS subsystem instance in the top-level SmartDesign and is clocked from the fabric clock.

Parameters:
- CLK_FREQ_HZ, 50000000, fabric clock frequency.
- BAUD, 115200, line rate.
- OVERSAMPLE, 16, oversampling ticks per bit; fixed at 16, not overridable.
- PARITY_ODD, 0, parity sense when parity is compiled in (0 = even, 1 = odd).

Ports:
- CLK0  in  1  fabric clock.
- DEVRST_N  in  1  asynchronous active-low reset.
- RX  in  1  serial input, asynchronous to CLK0; idle high.
- RX_DATA  out  8  received byte; LSB is the first bit on the wire.
- RX_VALID  out  1  RX_DATA holds an unconsumed byte.
- RX_READY  in  1  consumer accepts RX_DATA when RX_VALID && RX_READY.
- FRAMING_ERR  out  1  one-cycle pulse: stop bit sampled low.
- OVERRUN_ERR  out  1  one-cycle pulse: byte completed while holding register full.
- PARITY_ERR  out  1  one-cycle pulse: parity mismatch (0 when feature absent).
- BUSY  out  1  frame reception in progress (FSM not IDLE).

Behaviour:
- Reset: one clock (CLK0); reset is asynchronous and active-low (DEVRST_N).
  - In reset, all outputs = 0, RX_DATA = 8'h00, FSM = IDLE.
  - Synchroniser flops reset to 1, so a low RX at reset release is not taken as a start bit.
- RX passes through a 2-flop synchroniser.
- Tick generator:
  - DIVISOR = CLK_FREQ_HZ / (BAUD*16), integer truncation, minimum 1.
  - Free-running counter 0..DIVISOR-1; tick is a one-cycle strobe at wrap.
  - Counter restarts at 0 on each IDLE->START transition.
- Bit sampling: tick counter s = 0..15 within each bit; the bit value is the majority of synchronised samples at s = 7, 8, 9.
- FSM states and transitions:
  - IDLE: wait for synchronised RX = 0, then go to START with s = 0.
  - START: at s = 9 decide; majority 1 means glitch, return to IDLE with no flags; majority 0 means go to DATA after s = 15.
  - DATA: 8 bits, LSB first, into a shift register; after bit 7 go to PARITY (feature on) or STOP.
  - PARITY: one bit, compared at its s = 9.
  - STOP: decide at s = 9.
    - Majority 1: byte complete; return to IDLE at the same cycle, so the next start edge can be detected after half a stop bit.
    - Majority 0: pulse FRAMING_ERR, discard the byte, go to BREAK.
  - BREAK: wait for synchronised RX = 1, then go to IDLE. A held-low line produces exactly one FRAMING_ERR.
- Holding register:
  - RX_VALID rises on the clock after the stop-bit decision.
  - RX_VALID clears on a handshake unless a new byte loads in the same cycle; on handshake plus completion in the same cycle, the new byte loads and RX_VALID stays 1.
  - Completion while RX_VALID && !RX_READY: old byte kept, new byte dropped, OVERRUN_ERR pulses.
- A byte failing parity is still delivered, with PARITY_ERR pulsing in the cycle RX_VALID rises.
- Reset mid-frame aborts the frame immediately; no partial byte is ever delivered.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is start + 8 data + parity + stop.
  - Parity computed over the 8 data bits per PARITY_ODD.
  - Mismatch pulses PARITY_ERR.
- Undefined: frame is start + 8 data + stop; no PARITY state; PARITY_ERR tied to 0.

Decomposition:
- Package uart_fabric_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - OVERSAMPLE = 16 and DATA_BITS = 8 constants.
  - Divisor function with min-1 clamp.
- Sub-module uart_baud_tick: divisor counter with sync restart input and tick output. Reusable by a later fabric transmitter.

Test Plan:
- All tests use CLK_FREQ_HZ=1600000, BAUD=100000, so DIVISOR=1 and one bit = 16 clocks.
- Byte 0xA5, RX_READY=1 -> RX_DATA=0xA5, RX_VALID high exactly 1 cycle; no error pulses; BUSY high for the frame duration.
- RX low pulse of 4 clocks, then high -> FSM returns to IDLE; no RX_VALID, no FRAMING_ERR.
- Byte 0x3C with stop bit forced 0, line held low 40 clocks, then 0x55 -> one FRAMING_ERR; 0x3C not delivered; 0x55 delivered.
- RX_READY=0; send 0x11 then 0x22 -> RX_DATA stays 0x11; OVERRUN_ERR pulses once at the 0x22 completion; raise RX_READY -> 0x11 consumed and RX_VALID drops.
- Hold RX_READY high exactly in the 0x22 completion cycle with 0x11 pending -> 0x11 consumed; RX_DATA=0x22; RX_VALID stays 1; no OVERRUN_ERR.
- With UART_RX_PARITY_EN and PARITY_ODD=0: send 0x07 with parity bit 0 -> RX_DATA=0x07 delivered and PARITY_ERR pulses. Assert DEVRST_N low mid-data -> all outputs 0 immediately; after release, 0x80 is received correctly.

Source files
------------

// File: rtl/uart_fabric_pkg.sv
// Shared types and constants for the fabric-side UART blocks.
package uart_fabric_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Clocks per oversample tick; a too-fast baud request still yields one tick per clock.
    function automatic int unsigned baud_divisor(input int unsigned clk_hz,
                                                 input int unsigned baud);
        int unsigned d;
        d = clk_hz / (baud * OVERSAMPLE);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_fabric_rx_baud_tick.sv
// Oversample tick generator: free-running divisor counter, synchronously restartable.
module uart_baud_tick #(
    parameter int unsigned DIVISOR = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_fabric_rx.sv
// Fabric UART receiver: 16x oversampled, 3-sample majority vote, valid/ready holding register.
// Optional parity bit compiled in with `define UART_RX_PARITY_EN.
module uart_fabric_rx
    import uart_fabric_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic       CLK0,
    input  logic       DEVRST_N,
    input  logic       RX,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       FRAMING_ERR,
    output logic       OVERRUN_ERR,
    output logic       PARITY_ERR,
    output logic       BUSY
);

    localparam int unsigned DIVISOR = baud_divisor(CLK_FREQ_HZ, BAUD);

    rx_state_t  state, state_nxt;
    logic [3:0] s_cnt, s_nxt;
    logic [2:0] bit_idx, bit_nxt;
    logic       rx_p0, rx_p1;
    logic       samp7, samp8;
    logic       tick, restart, maj, mid, last_tick;
    logic       done_c, ferr_c, shift_en, par_err_c;
    logic [7:0] shreg;

    uart_baud_tick #(.DIVISOR(DIVISOR)) u_baud_tick (
        .clk     (CLK0),
        .rst_n   (DEVRST_N),
        .restart (restart),
        .tick    (tick)
    );

    // Stage p0/p1: metastability synchroniser, idle-high out of reset
    always_ff @(posedge CLK0 or negedge DEVRST_N) begin
        if (!DEVRST_N) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= RX;
            rx_p1 <= rx_p0;
        end
    end

    assign maj       = (samp7 & samp8) | (samp7 & rx_p1) | (samp8 & rx_p1);
    assign mid       = tick && (s_cnt == 4'd9);
    assign last_tick = tick && (s_cnt == 4'd15);
    assign BUSY      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        s_nxt     = s_cnt;
        bit_nxt   = bit_idx;
        restart   = 1'b0;
        done_c    = 1'b0;
        ferr_c    = 1'b0;
        shift_en  = 1'b0;
        if (tick && (state inside {START, DATA, PARITY, STOP}))
            s_nxt = s_cnt + 4'd1;
        case (state)
            IDLE: begin
                if (!rx_p1) begin
                    state_nxt = START;
                    s_nxt     = 4'd0;
                    restart   = 1'b1;
                end
            end
            START: begin
                if (mid && maj) begin
                    state_nxt = IDLE;
                end else if (last_tick) begin
                    state_nxt = DATA;
                    bit_nxt   = 3'd0;
                end
            end
            DATA: begin
                shift_en = mid;
                if (last_tick) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (last_tick)
                    state_nxt = STOP;
            end
`endif
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed
                if (mid) begin
                    if (maj) begin
                        done_c    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_c    = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_p1)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK0 or negedge DEVRST_N) begin
        if (!DEVRST_N) begin
            state   <= IDLE;
            s_cnt   <= 4'd0;
            bit_idx <= 3'd0;
            samp7   <= 1'b1;
            samp8   <= 1'b1;
        end else begin
            state   <= state_nxt;
            s_cnt   <= s_nxt;
            bit_idx <= bit_nxt;
            if (tick && (s_cnt == 4'd7))
                samp7 <= rx_p1;
            if (tick && (s_cnt == 4'd8))
                samp8 <= rx_p1;
        end
    end

    always_ff @(posedge CLK0) begin
        if (shift_en)
            shreg <= {maj, shreg[7:1]};
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge CLK0) begin
        if ((state == PARITY) && mid)
            par_bit <= maj;
    end

    assign par_err_c = (^{shreg, par_bit}) != (PARITY_ODD != 0);
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
    assign par_err_c         = 1'b0;
`endif

    // Stage p2: holding register and error pulses
    always_ff @(posedge CLK0 or negedge DEVRST_N) begin
        if (!DEVRST_N) begin
            RX_DATA     <= 8'h00;
            RX_VALID    <= 1'b0;
            FRAMING_ERR <= 1'b0;
            OVERRUN_ERR <= 1'b0;
            PARITY_ERR  <= 1'b0;
        end else begin
            FRAMING_ERR <= ferr_c;
            OVERRUN_ERR <= 1'b0;
            PARITY_ERR  <= 1'b0;
            if (done_c && (!RX_VALID || RX_READY)) begin
                RX_DATA    <= shreg;
                RX_VALID   <= 1'b1;
                PARITY_ERR <= par_err_c;
            end else begin
                if (done_c)
                    OVERRUN_ERR <= 1'b1;
                if (RX_VALID && RX_READY)
                    RX_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_fabric_rx.sv
// Directed bench for uart_fabric_rx at DIVISOR=1 (16 clocks per bit).
module tb_uart_fabric_rx;

`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int DONE_CYC = (NBITS - 1) * 16 + 12;
    localparam int FULL     = NBITS * 16;

    logic       CLK0 = 1'b0;
    logic       DEVRST_N;
    logic       RX;
    logic       RX_READY;
    logic [7:0] RX_DATA;
    logic       RX_VALID, FRAMING_ERR, OVERRUN_ERR, PARITY_ERR, BUSY;

    int tests = 0;
    int fails = 0;

    always #5 CLK0 = ~CLK0;

    uart_fabric_rx #(
        .CLK_FREQ_HZ (1600000),
        .BAUD        (100000),
        .PARITY_ODD  (0)
    ) dut (
        .CLK0        (CLK0),
        .DEVRST_N    (DEVRST_N),
        .RX          (RX),
        .RX_DATA     (RX_DATA),
        .RX_VALID    (RX_VALID),
        .RX_READY    (RX_READY),
        .FRAMING_ERR (FRAMING_ERR),
        .OVERRUN_ERR (OVERRUN_ERR),
        .PARITY_ERR  (PARITY_ERR),
        .BUSY        (BUSY)
    );

    int n_rise = 0, n_vhi = 0, n_hs = 0, n_ferr = 0, n_oerr = 0;
    int n_perr = 0, n_perr_rise = 0, n_busy = 0;
    logic [7:0] hs_data = 8'h00;
    logic       valid_q = 1'b0;

    always @(negedge CLK0) begin
        if (RX_VALID && !valid_q) n_rise <= n_rise + 1;
        if (RX_VALID) n_vhi <= n_vhi + 1;
        if (RX_VALID && RX_READY) begin
            n_hs    <= n_hs + 1;
            hs_data <= RX_DATA;
        end
        if (FRAMING_ERR) n_ferr <= n_ferr + 1;
        if (OVERRUN_ERR) n_oerr <= n_oerr + 1;
        if (PARITY_ERR) n_perr <= n_perr + 1;
        if (PARITY_ERR && RX_VALID && !valid_q) n_perr_rise <= n_perr_rise + 1;
        if (BUSY) n_busy <= n_busy + 1;
        valid_q <= RX_VALID;
    end

    int b_rise, b_vhi, b_hs, b_ferr, b_oerr, b_perr, b_busy;

    task automatic snap();
        b_rise = n_rise; b_vhi = n_vhi; b_hs = n_hs; b_ferr = n_ferr;
        b_oerr = n_oerr; b_perr = n_perr; b_busy = n_busy;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK0);
            #1;
        end
    endtask

    // Drives one frame, one bit per 16 clocks; optionally pulses RX_READY in the completion cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                              input bit rdy_pulse, input int max_cyc);
        logic [NBITS-1:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop_b, par_b, d, 1'b0};
`else
        bits = {stop_b, d, 1'b0};
        if (par_b) bits = {stop_b, d, 1'b0};
`endif
        for (int c = 0; c < FULL && c < max_cyc; c++) begin
            @(posedge CLK0);
            #1;
            RX = bits[c / 16];
            if (rdy_pulse) RX_READY = (c == DONE_CYC);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RX = 1'b1;
        RX_READY = 1'b1;
        DEVRST_N = 1'b0;
        idle(3);
        check("reset_data", RX_DATA, 8'h00);
        check("reset_valid", RX_VALID, 0);
        check("reset_busy", BUSY, 0);
        check("reset_errs", {FRAMING_ERR, OVERRUN_ERR, PARITY_ERR}, 0);
        DEVRST_N = 1'b1;
        idle(5);

        // Clean byte with consumer always ready
        snap();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, FULL);
        idle(4);
        check("a5_rise", n_rise - b_rise, 1);
        check("a5_valid_cycles", n_vhi - b_vhi, 1);
        check("a5_data", hs_data, 8'hA5);
        check("a5_errs", (n_ferr - b_ferr) + (n_oerr - b_oerr) + (n_perr - b_perr), 0);
        check("a5_busy_cycles", n_busy - b_busy, DONE_CYC - 2);
        check("a5_busy_end", BUSY, 0);

        // Short low glitch rejected at mid start bit
        snap();
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK0);
            #1;
            RX = 1'b0;
        end
        @(posedge CLK0);
        #1;
        RX = 1'b1;
        idle(30);
        check("glitch_busy_cycles", n_busy - b_busy, 10);
        check("glitch_busy", BUSY, 0);
        check("glitch_rise", n_rise - b_rise, 0);
        check("glitch_ferr", n_ferr - b_ferr, 0);

        // Stop bit low, line held low, then a good byte
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, FULL);
        RX = 1'b0;
        idle(40);
        RX = 1'b1;
        idle(20);
        check("brk_ferr", n_ferr - b_ferr, 1);
        check("brk_rise", n_rise - b_rise, 0);
        check("brk_busy", BUSY, 0);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, FULL);
        idle(5);
        check("brk_ferr_after", n_ferr - b_ferr, 1);
        check("brk_55_rise", n_rise - b_rise, 1);
        check("brk_55_data", hs_data, 8'h55);

        // Overrun: second byte dropped while first is pending
        RX_READY = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, FULL);
        idle(8);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, FULL);
        idle(8);
        check("ovr_data", RX_DATA, 8'h11);
        check("ovr_valid", RX_VALID, 1);
        check("ovr_pulses", n_oerr - b_oerr, 1);
        RX_READY = 1'b1;
        idle(1);
        RX_READY = 1'b0;
        idle(2);
        check("ovr_hs", n_hs - b_hs, 1);
        check("ovr_hs_data", hs_data, 8'h11);
        check("ovr_valid_drop", RX_VALID, 0);

        // Handshake coincides with completion of the next byte
        snap();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, FULL);
        idle(8);
        send_frame(8'h22, 1'b1, 1'b0, 1'b1, FULL);
        idle(4);
        check("hsdone_data", RX_DATA, 8'h22);
        check("hsdone_valid", RX_VALID, 1);
        check("hsdone_oerr", n_oerr - b_oerr, 0);
        check("hsdone_hs", n_hs - b_hs, 1);
        check("hsdone_hs_data", hs_data, 8'h11);
        RX_READY = 1'b1;
        idle(1);
        RX_READY = 1'b0;
        idle(2);
        check("hsdone_drain", hs_data, 8'h22);
        check("hsdone_valid_drop", RX_VALID, 0);

        // Reset mid-frame with a byte pending
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, FULL);
        idle(4);
        check("pre_rst_data", RX_DATA, 8'h5A);
        send_frame(8'h80, 1'b1, 1'b1, 1'b0, 16 * 4);
        check("pre_rst_busy", BUSY, 1);
        #2;
        DEVRST_N = 1'b0;
        #1;
        check("rst_mid_valid", RX_VALID, 0);
        check("rst_mid_data", RX_DATA, 8'h00);
        check("rst_mid_busy", BUSY, 0);
        check("rst_mid_errs", {FRAMING_ERR, OVERRUN_ERR, PARITY_ERR}, 0);
        RX = 1'b1;
        idle(2);
        DEVRST_N = 1'b1;
        snap();
        idle(20);
        check("rst_no_partial", n_rise - b_rise, 0);
        RX_READY = 1'b1;
        send_frame(8'h80, 1'b1, 1'b1, 1'b0, FULL);
        idle(5);
        check("rst_80_rise", n_rise - b_rise, 1);
        check("rst_80_data", hs_data, 8'h80);
        check("rst_80_ferr", n_ferr - b_ferr, 0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity 1; sending 0 must flag but still deliver
        snap();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, FULL);
        idle(5);
        check("par_data", hs_data, 8'h07);
        check("par_rise", n_rise - b_rise, 1);
        check("par_err", n_perr - b_perr, 1);
        check("par_err_at_rise", n_perr_rise, 1);
`else
        check("no_parity_err", n_perr, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
